// File: rtl/wb_dst_sel_if.sv
// wb_dst_sel_if: EX/DM source buses, hazard controls and DM/WB write-back bundle.
interface wb_dst_sel_if #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 5,
   parameter int ADDR_W  = 4
);
   logic [NUM_SRC*DATA_W-1:0] src_data_EX_DM;
   logic [NUM_SRC-1:0]        src_sel_EX_DM;
   logic                      we_EX_DM;
   logic [ADDR_W-1:0]         dst_addr_EX_DM;
   logic                      ext_vld;
   logic                      stall;
   logic                      flush;
   logic [DATA_W-1:0]         rf_w_data_DM_WB;
   logic                      rf_we_DM_WB;
   logic [ADDR_W-1:0]         rf_dst_addr_DM_WB;
   logic                      stall_req;
   logic                      ext_ack;
   logic                      ext_tmo;
   logic                      sel_multi;

   modport master (
      output src_data_EX_DM, src_sel_EX_DM, we_EX_DM, dst_addr_EX_DM, ext_vld, stall, flush,
      input  rf_w_data_DM_WB, rf_we_DM_WB, rf_dst_addr_DM_WB, stall_req, ext_ack, ext_tmo, sel_multi
   );
   modport slave (
      input  src_data_EX_DM, src_sel_EX_DM, we_EX_DM, dst_addr_EX_DM, ext_vld, stall, flush,
      output rf_w_data_DM_WB, rf_we_DM_WB, rf_dst_addr_DM_WB, stall_req, ext_ack, ext_tmo, sel_multi
   );
endinterface

// File: rtl/wb_dst_sel.sv
// wb_dst_sel: priority write-back source select into DM/WB, with stall/flush
// and a bounded wait state for the long-latency external source.
module wb_dst_sel #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 5,
   parameter int EXT_SRC = 3,
   parameter int ADDR_W  = 4,
   parameter int EXT_TMO = 16
) (
   input logic         clk,
   input logic         rst_n,
   wb_dst_sel_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_SRC);
   localparam int CNT_W = $clog2(EXT_TMO);
   localparam logic [SEL_W-1:0] EXT_IDX = SEL_W'(EXT_SRC);
   localparam logic [SEL_W-1:0] DEF_IDX = SEL_W'(NUM_SRC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(EXT_TMO - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              multi_q, multi_d;
   logic [SEL_W-1:0]  win;
   logic [DATA_W-1:0] win_data;
   logic              multi, ext_req, stall_req, ext_ack, ext_tmo;

   always_comb begin
      win = DEF_IDX;
      for (int i = NUM_SRC - 2; i >= 0; i--)
         if (bus.src_sel_EX_DM[i]) win = SEL_W'(i);
   end

   assign win_data = bus.src_data_EX_DM[win*DATA_W +: DATA_W];
   assign multi    = $countones(bus.src_sel_EX_DM) > 1;
   assign ext_req  = bus.we_EX_DM && (win == EXT_IDX);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      we_d      = we_q;
      addr_d    = addr_q;
      multi_d   = multi_q;
      stall_req = 1'b0;
      ext_ack   = 1'b0;
      ext_tmo   = 1'b0;
      if (bus.flush) begin
         we_d    = 1'b0;
         state_d = IDLE;
         cnt_d   = '0;
      end else if (!bus.stall) begin
         if (state_q == IDLE) begin
            if (ext_req && !bus.ext_vld) begin
               stall_req = 1'b1;
               we_d      = 1'b0;
               state_d   = WAIT;
               cnt_d     = CNT_W'(1);
            end else begin
               data_d  = win_data;
               we_d    = bus.we_EX_DM;
               addr_d  = bus.dst_addr_EX_DM;
               multi_d = multi;
               ext_ack = ext_req;
            end
         end else if (bus.ext_vld) begin
            // EX/DM was held by stall_req, so the buses still carry the waiting instruction
            ext_ack = 1'b1;
            data_d  = bus.src_data_EX_DM[EXT_SRC*DATA_W +: DATA_W];
            we_d    = 1'b1;
            addr_d  = bus.dst_addr_EX_DM;
            multi_d = multi;
            state_d = IDLE;
            cnt_d   = '0;
         end else if (cnt_q == TMO_LAST) begin
            ext_tmo = 1'b1;
            we_d    = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            stall_req = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         multi_q <= multi_d;
      end
   end

   assign bus.rf_w_data_DM_WB   = data_q;
   assign bus.rf_we_DM_WB       = we_q;
   assign bus.rf_dst_addr_DM_WB = addr_q;
   assign bus.sel_multi         = multi_q;
   assign bus.stall_req         = stall_req;
   assign bus.ext_ack           = ext_ack;
   assign bus.ext_tmo           = ext_tmo;
endmodule

// File: tb/tb_wb_dst_sel.sv
// tb_wb_dst_sel: directed vector table for single-cycle commits plus hand-written
// sequences for the external wait, timeout, stall/flush and mid-wait reset.
module tb_wb_dst_sel;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] src [5];
   int checks = 0;
   int failures = 0;

   wb_dst_sel_if #(.DATA_W(32), .NUM_SRC(5), .ADDR_W(4)) bus ();

   wb_dst_sel #(.DATA_W(32), .NUM_SRC(5), .EXT_SRC(3), .ADDR_W(4), .EXT_TMO(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;
   assign bus.src_data_EX_DM = {src[4], src[3], src[2], src[1], src[0]};

   typedef struct {
      logic [4:0]  sel;
      logic        we;
      logic [3:0]  addr;
      logic        vld, stl, fl;
      logic [31:0] e_data;
      logic        e_we;
      logic [3:0]  e_addr;
      logic        e_multi, e_sreq, e_ack;
   } vec_t;

   vec_t v [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [4:0] sel, input logic we, input logic [3:0] addr,
                         input logic vld, input logic stl, input logic fl);
      bus.src_sel_EX_DM  = sel;
      bus.we_EX_DM       = we;
      bus.dst_addr_EX_DM = addr;
      bus.ext_vld        = vld;
      bus.stall          = stl;
      bus.flush          = fl;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_regs(input string name, input logic [31:0] d, input logic we, input logic [3:0] a);
      chk({name, "_data"}, bus.rf_w_data_DM_WB, d);
      chk({name, "_we"}, {31'd0, bus.rf_we_DM_WB}, {31'd0, we});
      chk({name, "_addr"}, {28'd0, bus.rf_dst_addr_DM_WB}, {28'd0, a});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      src[0] = 32'hA000_0000;
      src[1] = 32'hDEAD_BEEF;
      src[2] = 32'h2222_2222;
      src[3] = 32'hCAFE_0001;
      src[4] = 32'h0000_1234;
      v[0] = '{5'b00110, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0};
      v[1] = '{5'b00000, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
      v[2] = '{5'b00001, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 32'hA000_0000, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
      v[3] = '{5'b10000, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0};
      v[4] = '{5'b00100, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0};
      v[5] = '{5'b00100, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0};
      v[6] = '{5'b01000, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1};
      v[7] = '{5'b11000, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0};
      v[8] = '{5'b00100, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0};
      v[9] = '{5'b01010, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};

      set_in(5'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      tick;
      chk_regs("reset", 32'h0, 1'b0, 4'd0);
      chk("reset_multi", {31'd0, bus.sel_multi}, 32'd0);
      chk("reset_sreq", {31'd0, bus.stall_req}, 32'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 10; k++) begin
         set_in(v[k].sel, v[k].we, v[k].addr, v[k].vld, v[k].stl, v[k].fl);
         chk($sformatf("vec%0d_sreq", k), {31'd0, bus.stall_req}, {31'd0, v[k].e_sreq});
         chk($sformatf("vec%0d_ack", k), {31'd0, bus.ext_ack}, {31'd0, v[k].e_ack});
         tick;
         chk_regs($sformatf("vec%0d", k), v[k].e_data, v[k].e_we, v[k].e_addr);
         chk($sformatf("vec%0d_multi", k), {31'd0, bus.sel_multi}, {31'd0, v[k].e_multi});
      end

      // external result arrives after four wait cycles
      for (int c = 0; c < 4; c++) begin
         set_in(5'b01000, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
         chk($sformatf("extw%0d_sreq", c), {31'd0, bus.stall_req}, 32'd1);
         chk($sformatf("extw%0d_ack", c), {31'd0, bus.ext_ack}, 32'd0);
         tick;
         chk($sformatf("extw%0d_we", c), {31'd0, bus.rf_we_DM_WB}, 32'd0);
      end
      set_in(5'b01000, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
      chk("extw_ack", {31'd0, bus.ext_ack}, 32'd1);
      chk("extw_sreq_low", {31'd0, bus.stall_req}, 32'd0);
      tick;
      chk_regs("extw_commit", 32'hCAFE_0001, 1'b1, 4'd3);

      // timeout: 15 cycles of stall_req, then a single ext_tmo pulse
      for (int c = 0; c < 15; c++) begin
         set_in(5'b01000, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
         chk($sformatf("tmo%0d_sreq", c), {31'd0, bus.stall_req}, 32'd1);
         chk($sformatf("tmo%0d_tmo", c), {31'd0, bus.ext_tmo}, 32'd0);
         tick;
         chk($sformatf("tmo%0d_we", c), {31'd0, bus.rf_we_DM_WB}, 32'd0);
      end
      chk("tmo_pulse", {31'd0, bus.ext_tmo}, 32'd1);
      chk("tmo_sreq_low", {31'd0, bus.stall_req}, 32'd0);
      tick;
      chk_regs("tmo_drop", 32'hCAFE_0001, 1'b0, 4'd3);
      set_in(5'b00000, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
      chk("tmo_after_pulse", {31'd0, bus.ext_tmo}, 32'd0);
      tick;
      chk_regs("tmo_next", 32'h0000_1234, 1'b1, 4'd11);

      // stall freezes a pending commit for three cycles
      for (int c = 0; c < 3; c++) begin
         set_in(5'b00010, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0);
         chk($sformatf("stl%0d_sreq", c), {31'd0, bus.stall_req}, 32'd0);
         tick;
         chk_regs($sformatf("stl%0d", c), 32'h0000_1234, 1'b1, 4'd11);
      end
      set_in(5'b00010, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
      tick;
      chk_regs("stl_release", 32'hDEAD_BEEF, 1'b1, 4'd12);
      for (int c = 0; c < 2; c++) begin
         set_in(5'b01000, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
         tick;
      end
      set_in(5'b01000, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
      chk("flush_no_ack", {31'd0, bus.ext_ack}, 32'd0);
      tick;
      chk_regs("flush", 32'hDEAD_BEEF, 1'b0, 4'd12);
      set_in(5'b01000, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
      chk("stall_vld_no_ack", {31'd0, bus.ext_ack}, 32'd0);
      set_in(5'b00010, 1'b1, 4'd13, 1'b0, 1'b1, 1'b1);
      tick;
      chk_regs("flush_stall", 32'hDEAD_BEEF, 1'b0, 4'd12);

      // ext_vld on the final wait cycle beats the timeout
      src[3] = 32'hCAFE_0002;
      for (int c = 0; c < 15; c++) begin
         set_in(5'b01000, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
         tick;
      end
      set_in(5'b01000, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0);
      chk("edge_ack", {31'd0, bus.ext_ack}, 32'd1);
      chk("edge_tmo", {31'd0, bus.ext_tmo}, 32'd0);
      tick;
      chk_regs("edge_commit", 32'hCAFE_0002, 1'b1, 4'd10);

      // asynchronous reset with the wait counter at 5
      for (int c = 0; c < 5; c++) begin
         set_in(5'b01000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
         tick;
      end
      set_in(5'b00000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_regs("async_rst", 32'h0, 1'b0, 4'd0);
      chk("async_rst_multi", {31'd0, bus.sel_multi}, 32'd0);
      chk("async_rst_sreq", {31'd0, bus.stall_req}, 32'd0);
      tick;
      rst_n = 1'b1;
      set_in(5'b00010, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      tick;
      chk_regs("post_rst", 32'hDEAD_BEEF, 1'b1, 4'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_dst_sel.md
Name: wb_dst_sel

Overview:
- Parametrised registered write-back source select between the EX/DM and DM/WB stages.
- Picks one of NUM_SRC result buses by fixed priority and registers the data, write enable and destination address toward the register file.
- Adds stall/flush handling.
- Adds a wait state for a long-latency external source (external ALU) with a valid/ack handshake and a timeout.

Parameters:
DATA_W, 32, width of every source bus and of the write-back data
NUM_SRC, 5, number of source buses; index NUM_SRC-1 is the default (internal ALU)
EXT_SRC, 3, index of the long-latency external source; must be < NUM_SRC-1
ADDR_W, 4, register-file address width
EXT_TMO, 16, max cycles spent waiting for ext_vld; must be >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
src_data_EX_DM  input  NUM_SRC*DATA_W  concatenated source buses; source i at bits [i*DATA_W +: DATA_W]
src_sel_EX_DM  input  NUM_SRC  source request bits; lowest set index wins
we_EX_DM  input  1  instruction in EX/DM writes the RF
dst_addr_EX_DM  input  ADDR_W  RF destination address
ext_vld  input  1  external source result valid; level, held until ext_ack
stall  input  1  hazard unit hold of the DM/WB register
flush  input  1  kill the instruction entering DM/WB
rf_w_data_DM_WB  output  DATA_W  registered write-back data
rf_we_DM_WB  output  1  registered write enable
rf_dst_addr_DM_WB  output  ADDR_W  registered destination address
stall_req  output  1  combinational; upstream must hold EX/DM while 1
ext_ack  output  1  one-cycle pulse when the external result is captured
ext_tmo  output  1  one-cycle pulse on external timeout
sel_multi  output  1  registered: more than one src_sel bit was set on the last commit

Behaviour:
Reset (rst_n=0, asynchronous):
- All outputs 0, state IDLE, wait counter 0.

Source select:
- win = lowest index i with src_sel_EX_DM[i]=1.
- If no bit is set, win = NUM_SRC-1.
- Data is passed through unchanged; there is no width conversion.

Priority each cycle: flush > stall > FSM.
- flush=1: next edge rf_we_DM_WB=0. Data and address hold. State returns to IDLE, counter cleared, no ext_ack.
- stall=1 (flush=0): all registers, state and counter hold. stall_req=0. ext_ack/ext_tmo stay 0.

FSM IDLE:
- Condition: we_EX_DM=1, win=EXT_SRC, ext_vld=0.
  - stall_req=1 the same cycle.
  - Next edge: rf_we_DM_WB=0 (bubble); go to WAIT; counter=1.
- Otherwise commit, 1-cycle latency:
  - rf_w_data_DM_WB = src win.
  - rf_we_DM_WB = we_EX_DM.
  - rf_dst_addr_DM_WB = dst_addr_EX_DM.
  - sel_multi = popcount(src_sel_EX_DM)>1.
  - If win=EXT_SRC and we_EX_DM=1 with ext_vld=1: ext_ack=1 that cycle, no wait.

FSM WAIT (EX/DM inputs are stable because stall_req=1):
- ext_vld=1: stall_req=0 and ext_ack=1 combinationally.
  - Next edge: commit src EXT_SRC with we=1 and address dst_addr_EX_DM; go to IDLE; counter=0.
- ext_vld=0 and counter=EXT_TMO-1:
  - stall_req=0, ext_tmo=1.
  - Next edge: rf_we_DM_WB=0, data/address hold, go to IDLE.
  - The instruction is dropped; the exception unit handles it.
- Else: stall_req=1; counter+1.
- ext_vld and timeout in the same cycle: ext_vld wins.

Other rules:
- ext_ack is asserted only when the captured value is actually registered, never while stall=1 or flush=1.
- rf_we_DM_WB is 0 in every bubble; data is never cleared except by reset.

Test Plan:
- Reset with rst_n low mid-WAIT (counter=5) -> all outputs 0 immediately, state IDLE; after release the first commit has 1-cycle latency.
- src_sel=5'b00110, we=1, addr=7, src1=32'hDEAD_BEEF -> next edge data=DEADBEEF, we=1, addr=7, sel_multi=1. src_sel=0 with src4=32'h1234 -> data=00001234, sel_multi=0.
- Ext path, src_sel=5'b01000, we=1, addr=3, ext_vld low for 4 cycles then high with src3=32'hCAFE_0001:
  - stall_req high for 4 cycles; rf_we=0 during the wait.
  - ext_ack pulses on cycle 5.
  - Next edge data=CAFE0001, we=1, addr=3; stall_req low.
- Ext timeout, ext_vld never asserted, EXT_TMO=16 -> stall_req high 15 cycles; ext_tmo single pulse; rf_we stays 0; FSM back in IDLE and accepts next ALU commit on following edge.
- stall=1 for 3 cycles during a commit, then flush=1 while in WAIT:
  - Outputs frozen through the stall.
  - On flush: rf_we=0 next edge, counter cleared, no ext_ack.
  - flush+stall together -> flush behaviour.
- ext_vld=1 on the same cycle counter reaches EXT_TMO-1 -> ext_ack=1, ext_tmo=0, result committed.
